// File: rtl/cv32e40px_instr_packer_if.sv
`default_nettype none
// ============================================================================
//  Module   : cv32e40px_instr_packer_if
//  Purpose  : Bundles the stream-control, instruction and packed-word
//             handshake signals of the instruction packer.
//  Ports    : start_i/start_addr_i  - stream restart and its byte address
//             instr_valid_i/instr_ready_o/instr_i - instruction handshake
//             flush_i               - request to emit a held halfword
//             word_valid_o/word_ready_i/word_o/word_addr_o/word_be_o
//                                   - packed-word output handshake
//             pc_o                  - address of the next accepted instruction
//             idle_o                - nothing held and nothing pending
//  Modports : slave  - the packer itself
//             master - the environment driving it
//  Revision : 1.0 - initial release
// ============================================================================
interface cv32e40px_instr_packer_if;
   logic        start_i;
   logic [31:0] start_addr_i;
   logic        instr_valid_i;
   logic        instr_ready_o;
   logic [31:0] instr_i;
   logic        flush_i;
   logic        word_valid_o;
   logic        word_ready_i;
   logic [31:0] word_o;
   logic [31:0] word_addr_o;
   logic [3:0]  word_be_o;
   logic [31:0] pc_o;
   logic        idle_o;

   modport slave (
      input  start_i, start_addr_i, instr_valid_i, instr_i, flush_i, word_ready_i,
      output instr_ready_o, word_valid_o, word_o, word_addr_o, word_be_o, pc_o, idle_o
   );

   modport master (
      output start_i, start_addr_i, instr_valid_i, instr_i, flush_i, word_ready_i,
      input  instr_ready_o, word_valid_o, word_o, word_addr_o, word_be_o, pc_o, idle_o
   );
endinterface
`default_nettype wire

// File: rtl/cv32e40px_instr_packer.sv
`default_nettype none
// ============================================================================
//  Module   : cv32e40px_instr_packer
//  Purpose  : Packs a stream of 16/32-bit instructions densely into
//             little-endian 32-bit words with byte enables, producing the
//             memory image the fetch-side aligner consumes.
//  Ports    : clk  - rising-edge clock
//             rst  - synchronous active-high reset
//             bus  - cv32e40px_instr_packer_if.slave (start, instruction
//                    handshake, flush, packed-word handshake, pc, idle)
//  Revision : 1.0 - initial release
// ============================================================================
module cv32e40px_instr_packer (
   input  wire logic                     clk,
   input  wire logic                     rst,
   cv32e40px_instr_packer_if.slave       bus
);

   // ALIGNED  : pc on a word boundary, nothing held
   // HALF     : pc on a halfword boundary, low halfword of the word in hold_q
   // START_MIS: stream began on a halfword boundary, nothing held
   typedef enum logic [1:0] {
      ST_ALIGNED   = 2'd0,
      ST_HALF      = 2'd1,
      ST_START_MIS = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [15:0] hold_q, hold_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] word_q, word_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;

   logic        slot_free;
   logic        accept;
   logic        is_32;
   logic        emit;
   logic [31:0] pc_base;

   // The output buffer can take a new word if empty or being drained now,
   // which gives zero-bubble replacement under continuous word_ready_i.
   assign slot_free         = !out_valid_q || bus.word_ready_i;
   assign bus.instr_ready_o = !bus.start_i && slot_free;
   assign accept            = bus.instr_valid_i && bus.instr_ready_o;
   assign is_32             = (bus.instr_i[1:0] == 2'b11);
   assign pc_base           = {pc_q[31:2], 2'b00};

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      hold_d      = hold_q;
      out_valid_d = out_valid_q;
      word_d      = word_q;
      addr_d      = addr_q;
      be_d        = be_q;
      emit        = 1'b0;

      if (bus.start_i) begin
         // Restart discards both the held halfword and any pending word.
         out_valid_d = 1'b0;
         hold_d      = 16'h0000;
         pc_d        = bus.start_addr_i & 32'hFFFF_FFFE;
         state_d     = bus.start_addr_i[1] ? ST_START_MIS : ST_ALIGNED;
      end else begin
         if (accept) begin
            pc_d   = pc_q + (is_32 ? 32'd4 : 32'd2);
            addr_d = pc_base;
            case (state_q)
               ST_ALIGNED: begin
                  if (is_32) begin
                     emit   = 1'b1;
                     word_d = bus.instr_i;
                     be_d   = 4'b1111;
                  end else begin
                     hold_d  = bus.instr_i[15:0];
                     state_d = ST_HALF;
                  end
               end
               ST_HALF: begin
                  emit   = 1'b1;
                  word_d = {bus.instr_i[15:0], hold_q};
                  be_d   = 4'b1111;
                  if (is_32) begin
                     // Upper half of a straddling instruction starts the next word.
                     hold_d = bus.instr_i[31:16];
                  end else begin
                     state_d = ST_ALIGNED;
                  end
               end
               ST_START_MIS: begin
                  emit   = 1'b1;
                  word_d = {bus.instr_i[15:0], 16'h0000};
                  be_d   = 4'b1100;
                  if (is_32) begin
                     hold_d  = bus.instr_i[31:16];
                     state_d = ST_HALF;
                  end else begin
                     state_d = ST_ALIGNED;
                  end
               end
               default: begin
                  state_d = ST_ALIGNED;
               end
            endcase
         end else if ((state_q == ST_HALF) && bus.flush_i && slot_free) begin
            // Emit the lone held halfword; the next instruction starts a fresh word.
            emit    = 1'b1;
            word_d  = {16'h0000, hold_q};
            be_d    = 4'b0011;
            addr_d  = pc_base;
            pc_d    = pc_base + 32'd4;
            state_d = ST_ALIGNED;
         end

         if (emit) begin
            out_valid_d = 1'b1;
         end else if (out_valid_q && bus.word_ready_i) begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_ALIGNED;
         pc_q        <= 32'h0;
         hold_q      <= 16'h0;
         out_valid_q <= 1'b0;
         word_q      <= 32'h0;
         addr_q      <= 32'h0;
         be_q        <= 4'h0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         hold_q      <= hold_d;
         out_valid_q <= out_valid_d;
         word_q      <= word_d;
         addr_q      <= addr_d;
         be_q        <= be_d;
      end
   end

   assign bus.word_valid_o = out_valid_q;
   assign bus.word_o       = word_q;
   assign bus.word_addr_o  = addr_q;
   assign bus.word_be_o    = be_q;
   assign bus.pc_o         = pc_q;
   assign bus.idle_o       = !out_valid_q && (state_q != ST_HALF);

endmodule
`default_nettype wire

// File: tb/tb_cv32e40px_instr_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cv32e40px_instr_packer
//  Purpose  : Self-checking bench for cv32e40px_instr_packer. A reference
//             packing model pushes expected words into a queue as each
//             instruction or flush is driven; a monitor pops and compares
//             on every output handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cv32e40px_instr_packer;

   localparam int M_AL   = 0;
   localparam int M_HALF = 1;
   localparam int M_MIS  = 2;

   typedef struct packed {
      logic [31:0] w;
      logic [31:0] a;
      logic [3:0]  be;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cv32e40px_instr_packer_if bus ();

   cv32e40px_instr_packer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t        q[$];
   int          checks = 0;
   int          passes = 0;
   int          fails  = 0;
   int          last_wait = 0;
   bit          rand_mode = 1'b0;

   int          m_state = M_AL;
   logic [31:0] m_pc    = 32'h0;
   logic [15:0] m_hold  = 16'h0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] w, input logic [31:0] a, input logic [3:0] be);
      exp_t e;
      e.w  = w;
      e.a  = a;
      e.be = be;
      q.push_back(e);
   endtask

   // Reference packing model, written from the packing rules.
   task automatic model_accept(input logic [31:0] ins);
      logic [31:0] base;
      bit          big;
      base = {m_pc[31:2], 2'b00};
      big  = (ins[1:0] == 2'b11);
      case (m_state)
         M_AL: begin
            if (big) push(ins, base, 4'b1111);
            else begin
               m_hold  = ins[15:0];
               m_state = M_HALF;
            end
         end
         M_HALF: begin
            push({ins[15:0], m_hold}, base, 4'b1111);
            if (big) m_hold = ins[31:16];
            else     m_state = M_AL;
         end
         default: begin
            push({ins[15:0], 16'h0000}, base, 4'b1100);
            if (big) begin
               m_hold  = ins[31:16];
               m_state = M_HALF;
            end else begin
               m_state = M_AL;
            end
         end
      endcase
      m_pc = m_pc + (big ? 32'd4 : 32'd2);
   endtask

   // Output monitor: compares each completed handshake with the scoreboard
   // and checks that a stalled word holds its fields.
   logic        stall_prev = 1'b0;
   logic [31:0] sw, sa;
   logic [3:0]  sb;
   always @(negedge clk) begin
      if (rst) begin
         stall_prev <= 1'b0;
      end else begin
         if (stall_prev && bus.word_valid_o) begin
            check("stall_word", bus.word_o, sw);
            check("stall_addr", bus.word_addr_o, sa);
            check("stall_be", {28'h0, bus.word_be_o}, {28'h0, sb});
         end
         if (bus.word_valid_o && bus.word_ready_i) begin
            if (q.size() == 0) begin
               check("unexpected_word", bus.word_o, 32'hDEAD_BEEF);
            end else begin
               check("sb_word", bus.word_o, q[0].w);
               check("sb_addr", bus.word_addr_o, q[0].a);
               check("sb_be", {28'h0, bus.word_be_o}, {28'h0, q[0].be});
               void'(q.pop_front());
            end
         end
         stall_prev <= bus.word_valid_o && !bus.word_ready_i && !bus.start_i;
         sw <= bus.word_o;
         sa <= bus.word_addr_o;
         sb <= bus.word_be_o;
      end
   end

   // Present one instruction; waits a bounded number of cycles for ready.
   task automatic send(input logic [31:0] ins);
      int n;
      bus.instr_valid_i = 1'b1;
      bus.instr_i       = ins;
      n = 0;
      @(negedge clk);
      while (!bus.instr_ready_o && n < 20) begin
         @(posedge clk);
         #1;
         if (rand_mode) bus.word_ready_i = 1'b1;
         n++;
         @(negedge clk);
      end
      last_wait = n;
      if (!bus.instr_ready_o) check("instr_ready_timeout", 32'h0, 32'h1);
      else                    model_accept(ins);
      @(posedge clk);
      #1;
      bus.instr_valid_i = 1'b0;
      bus.instr_i       = $urandom;
      if (rand_mode) bus.word_ready_i = 1'($urandom_range(0, 1));
   endtask

   task automatic do_flush();
      bus.word_ready_i = 1'b1;
      bus.flush_i      = 1'b1;
      @(negedge clk);
      if (m_state == M_HALF) begin
         push({16'h0000, m_hold}, {m_pc[31:2], 2'b00}, 4'b0011);
         m_pc    = {m_pc[31:2], 2'b00} + 32'd4;
         m_state = M_AL;
      end
      @(posedge clk);
      #1;
      bus.flush_i = 1'b0;
   endtask

   task automatic do_start(input logic [31:0] addr);
      bus.start_i      = 1'b1;
      bus.start_addr_i = addr;
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      q.delete();
      m_pc    = addr & 32'hFFFF_FFFE;
      m_hold  = 16'h0;
      m_state = addr[1] ? M_MIS : M_AL;
      check("start_clears_valid", {31'h0, bus.word_valid_o}, 32'h0);
      check("start_pc", bus.pc_o, m_pc);
   endtask

   task automatic drain();
      int n;
      bus.word_ready_i = 1'b1;
      n = 0;
      while (q.size() != 0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", q.size(), 32'h0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] r;
      rst               = 1'b1;
      bus.start_i       = 1'b0;
      bus.start_addr_i  = 32'h0;
      bus.instr_valid_i = 1'b0;
      bus.instr_i       = 32'h0;
      bus.flush_i       = 1'b0;
      bus.word_ready_i  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", {31'h0, bus.word_valid_o}, 32'h0);
      check("rst_idle", {31'h0, bus.idle_o}, 32'h1);
      check("rst_pc", bus.pc_o, 32'h0);
      check("rst_word", bus.word_o, 32'h0);
      check("rst_addr", bus.word_addr_o, 32'h0);
      check("rst_be", {28'h0, bus.word_be_o}, 32'h0);
      rst = 1'b0;

      // Single aligned 32-bit instruction
      do_start(32'h0000_1000);
      send(32'h00A0_0093);
      check("t1_word", bus.word_o, 32'h00A0_0093);
      check("t1_addr", bus.word_addr_o, 32'h0000_1000);
      check("t1_be", {28'h0, bus.word_be_o}, 32'hF);
      check("t1_pc", bus.pc_o, 32'h0000_1004);
      drain();

      // Mixed 16/32 packing
      do_start(32'h0000_2000);
      send(32'h0000_4501);
      send(32'h00B0_0113);
      check("t2_word0", bus.word_o, 32'h0113_4501);
      check("t2_addr0", bus.word_addr_o, 32'h0000_2000);
      send(32'h0000_4605);
      check("t2_word1", bus.word_o, 32'h4605_00B0);
      check("t2_addr1", bus.word_addr_o, 32'h0000_2004);
      check("t2_be1", {28'h0, bus.word_be_o}, 32'hF);
      drain();
      check("t2_idle", {31'h0, bus.idle_o}, 32'h1);
      check("t2_pc", bus.pc_o, 32'h0000_2008);

      // Misaligned start, straddling instruction, flush
      do_start(32'h0000_3002);
      send(32'h1234_5693);
      check("t3_word0", bus.word_o, 32'h5693_0000);
      check("t3_addr0", bus.word_addr_o, 32'h0000_3000);
      check("t3_be0", {28'h0, bus.word_be_o}, 32'hC);
      drain();
      check("t3_half_not_idle", {31'h0, bus.idle_o}, 32'h0);
      do_flush();
      check("t3_word1", bus.word_o, 32'h0000_1234);
      check("t3_addr1", bus.word_addr_o, 32'h0000_3004);
      check("t3_be1", {28'h0, bus.word_be_o}, 32'h3);
      check("t3_pc", bus.pc_o, 32'h0000_3008);
      drain();
      check("t3_idle", {31'h0, bus.idle_o}, 32'h1);

      // Flush ignored when aligned
      do_flush();
      check("t4_flush_ign_valid", {31'h0, bus.word_valid_o}, 32'h0);
      check("t4_flush_ign_pc", bus.pc_o, 32'h0000_3008);

      // Output backpressure, then zero-bubble release
      do_start(32'h0000_4000);
      bus.word_ready_i = 1'b0;
      send(32'h0000_0013);
      bus.instr_valid_i = 1'b1;
      bus.instr_i       = 32'h0010_0093;
      repeat (5) begin
         @(negedge clk);
         check("t5_ready_low", {31'h0, bus.instr_ready_o}, 32'h0);
         @(posedge clk);
         #1;
      end
      bus.word_ready_i = 1'b1;
      send(32'h0010_0093);
      check("t5_wait0", last_wait, 32'h0);
      send(32'h0020_0113);
      check("t5_wait1", last_wait, 32'h0);
      check("t5_valid1", {31'h0, bus.word_valid_o}, 32'h1);
      send(32'h0030_0193);
      check("t5_wait2", last_wait, 32'h0);
      check("t5_addr2", bus.word_addr_o, 32'h0000_400C);
      drain();

      // Address wrap, then restart drops the pending word
      do_start(32'hFFFF_FFFC);
      bus.word_ready_i = 1'b0;
      send(32'h0020_0113);
      check("t6_addr", bus.word_addr_o, 32'hFFFF_FFFC);
      check("t6_pc_wrap", bus.pc_o, 32'h0000_0000);
      check("t6_pending", {31'h0, bus.word_valid_o}, 32'h1);
      do_start(32'h0000_5000);
      bus.word_ready_i = 1'b1;

      // Reset mid-stream discards the held halfword
      do_start(32'h0000_6000);
      send(32'h0000_0001);
      check("t7_half", {31'h0, bus.idle_o}, 32'h0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      m_pc = 32'h0; m_hold = 16'h0; m_state = M_AL;
      check("t7_idle", {31'h0, bus.idle_o}, 32'h1);
      check("t7_pc", bus.pc_o, 32'h0);
      check("t7_valid", {31'h0, bus.word_valid_o}, 32'h0);

      // Random mixed stream with random backpressure and flushes
      rand_mode = 1'b1;
      do_start(32'h0000_8000 + 32'($urandom_range(0, 1) * 2));
      for (int i = 0; i < 60; i++) begin
         r = $urandom;
         if ($urandom_range(0, 1) == 1) r[1:0] = 2'b11;
         else                           r[1:0] = 2'($urandom_range(0, 2));
         send(r);
         if ($urandom_range(0, 7) == 0) do_flush();
      end
      do_flush();
      rand_mode = 1'b0;
      drain();
      check("rand_pc", bus.pc_o, m_pc);
      check("rand_idle", {31'h0, bus.idle_o}, 32'h1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
